// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK counter controller: command opcodes and FSM states.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/jk_count_ctrl_if.sv
// Command channel into the JK counter controller: valid/ready plus opcode, load data and step count.
interface jk_count_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_op, output cmd_data, output cmd_len,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, input  cmd_len,
                    output cmd_ready);
endinterface

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops: JK=00 hold, 01 clear, 10 set, 11 toggle.
module jk_bank #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
                2'b00:   q_d[i] = q_q[i];
                2'b01:   q_d[i] = 1'b0;
                2'b10:   q_d[i] = 1'b1;
                default: q_d[i] = ~q_q[i];
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/jk_count_ctrl.sv
// Command sequencer driving the J/K inputs of a JK register bank: load, clear, count up/down N steps.
module jk_count_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    jk_count_ctrl_if.slave   cmd,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] j, k;
    logic             is_count, step;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] cur,
                                                     input logic down);
        logic [WIDTH-1:0] m;
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i]  = carry;
            carry = carry & (cur[i] ^ down);
        end
        return m;
    endfunction

    assign is_count = (op_q == OP_UP) || (op_q == OP_DOWN);
    assign step     = (state_q == ST_RUN) && is_count && (remain_q != '0) && !abort;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOAD;
            data_q   <= '0;
            remain_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            remain_q <= remain_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        remain_d = remain_q;
        wrap_d   = step && (((op_q == OP_UP) && (&q)) || ((op_q == OP_DOWN) && (q == '0)));
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d     = op_e'(cmd.cmd_op);
                    data_d   = cmd.cmd_data;
                    remain_d = cmd.cmd_len;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!is_count || abort || (remain_q == '0)) begin
                    state_d = ST_DONE;
                end else begin
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        j = '0;
        k = '0;
        if (state_q == ST_RUN) begin
            case (op_q)
                OP_LOAD: begin
                    j = data_q;
                    k = ~data_q;
                end
                OP_CLEAR: k = '1;
                default: begin
                    if (step) begin
                        j = toggle_mask(q, op_q == OP_DOWN);
                        k = j;
                    end
                end
            endcase
        end
        busy          = (state_q != ST_IDLE);
        cmd.cmd_ready = (state_q == ST_IDLE);
        done          = (state_q == ST_DONE);
        wrap          = wrap_q;
    end

    jk_bank #(.WIDTH(WIDTH)) u_bank (
        .CLK (CLK),
        .RST (RST),
        .j   (j),
        .k   (k),
        .q   (q)
    );
endmodule

// File: tb/tb_jk_count_ctrl.sv
// Self-checking bench for jk_count_ctrl: directed table, trace checks, random commands vs. model, async reset.
module tb_jk_count_ctrl;
    import jk_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       abort = 1'b0;
    logic [7:0] q;
    logic       busy, done, wrap;

    jk_count_ctrl_if #(.WIDTH(8), .LEN_W(8)) cif ();

    jk_count_ctrl #(.WIDTH(8), .LEN_W(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .cmd   (cif),
        .abort (abort),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [7:0] q_tr [512];
    logic       w_tr [512];
    logic       d_tr [512];
    int         n;
    logic       timed_out;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] len;
        int         abort_at;
        logic [7:0] exp_q;
        int         exp_w;
        int         exp_busy;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        int         wraps;
        int         busy;
    } res_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: what one command does to q, counted in whole steps rather than cycles.
    function automatic res_t model(input logic [1:0] op, input logic [7:0] len,
                                   input int abort_at, input logic [7:0] data,
                                   input logic [7:0] q_in);
        res_t r;
        int span, steps, v;
        bit counting, ab;
        counting = (op == OP_UP) || (op == OP_DOWN);
        span     = (len == 0) ? 1 : int'(len);
        ab       = counting && (abort_at != 0) && (abort_at <= span);
        steps    = !counting ? 0 : (ab ? abort_at - 1 : int'(len));
        r.busy   = (!counting ? 1 : (ab ? abort_at : span)) + 1;
        r.wraps  = 0;
        r.q      = q_in;
        if (op == OP_LOAD)  r.q = data;
        if (op == OP_CLEAR) r.q = 8'h00;
        if (op == OP_UP) begin
            v       = int'(q_in) + steps;
            r.wraps = v / 256;
            r.q     = 8'(v % 256);
        end
        if (op == OP_DOWN) begin
            v       = int'(q_in) - steps;
            r.wraps = (v >= 0) ? 0 : ((-v - 1) / 256 + 1);
            r.q     = 8'(((v % 256) + 256) % 256);
        end
        return r;
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data,
                          input logic [7:0] len, input int abort_at);
        int guard;
        int c;
        timed_out = 1'b0;
        n = 0;
        guard = 0;
        @(negedge CLK);
        while (!cif.cmd_ready && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (!cif.cmd_ready) begin
            timed_out = 1'b1;
            return;
        end
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = data;
        cif.cmd_len   = len;
        @(posedge CLK);
        #1;
        cif.cmd_valid = 1'b0;
        cif.cmd_data  = 8'($urandom);
        cif.cmd_len   = 8'($urandom);
        c = 1;
        abort = (c == abort_at);
        while (busy && n < 400) begin
            q_tr[n] = q;
            w_tr[n] = wrap;
            d_tr[n] = done;
            n++;
            @(posedge CLK);
            #1;
            c++;
            abort = (c == abort_at);
        end
        abort = 1'b0;
        if (busy) timed_out = 1'b1;
    endtask

    task automatic check_cmd(input string tag, input logic [7:0] exp_q,
                             input int exp_w, input int exp_busy);
        int wc, dc;
        wc = 0;
        dc = 0;
        for (int i = 0; i < n; i++) begin
            wc += int'(w_tr[i]);
            dc += int'(d_tr[i]);
        end
        chk({tag, "_timeout"}, int'(timed_out), 0);
        chk({tag, "_q"}, int'(q), int'(exp_q));
        chk({tag, "_wraps"}, wc, exp_w);
        chk({tag, "_busy_cycles"}, n, exp_busy);
        chk({tag, "_done_count"}, dc, 1);
        chk({tag, "_done_last"}, (n > 0) ? int'(d_tr[n-1]) : 0, 1);
        chk({tag, "_ready"}, int'(cif.cmd_ready), 1);
    endtask

    initial begin
        res_t       r;
        logic [7:0] mq;
        logic [1:0] rop;
        logic [7:0] rdata, rlen;
        int         rab, guard, dcount;

        vecs[0]  = '{OP_LOAD,  8'hA5, 8'd0,   0, 8'hA5, 0, 2};
        vecs[1]  = '{OP_LOAD,  8'hFE, 8'd0,   0, 8'hFE, 0, 2};
        vecs[2]  = '{OP_UP,    8'h00, 8'd3,   0, 8'h01, 1, 4};
        vecs[3]  = '{OP_LOAD,  8'h01, 8'd0,   0, 8'h01, 0, 2};
        vecs[4]  = '{OP_DOWN,  8'h00, 8'd2,   0, 8'hFF, 1, 3};
        vecs[5]  = '{OP_LOAD,  8'h3C, 8'd0,   0, 8'h3C, 0, 2};
        vecs[6]  = '{OP_UP,    8'h00, 8'd0,   0, 8'h3C, 0, 2};
        vecs[7]  = '{OP_CLEAR, 8'hFF, 8'd9,   0, 8'h00, 0, 2};
        vecs[8]  = '{OP_UP,    8'h00, 8'd10,  4, 8'h03, 0, 5};
        vecs[9]  = '{OP_DOWN,  8'h00, 8'd5,   0, 8'hFE, 1, 6};
        vecs[10] = '{OP_LOAD,  8'h80, 8'd0,   1, 8'h80, 0, 2};
        vecs[11] = '{OP_DOWN,  8'h00, 8'd0,   1, 8'h80, 0, 2};
        vecs[12] = '{OP_UP,    8'h00, 8'd255, 0, 8'h7F, 1, 256};

        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_data  = 8'h00;
        cif.cmd_len   = 8'h00;
        #2;
        chk("reset_q", int'(q), 0);
        chk("reset_ready", int'(cif.cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wrap", int'(wrap), 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_cmd(vecs[i].op, vecs[i].data, vecs[i].len, vecs[i].abort_at);
            check_cmd($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_w, vecs[i].exp_busy);
            if (i == 0) chk("vec0_q_in_done", int'(q_tr[1]), 'hA5);
            if (i == 2 && n == 4) begin
                chk("up3_q0", int'(q_tr[0]), 'hFE);
                chk("up3_q1", int'(q_tr[1]), 'hFF);
                chk("up3_q2", int'(q_tr[2]), 'h00);
                chk("up3_q3", int'(q_tr[3]), 'h01);
                chk("up3_wrap_at_00", int'(w_tr[2]), 1);
            end
            if (i == 4 && n == 3) begin
                chk("dn2_q1", int'(q_tr[1]), 'h00);
                chk("dn2_q2", int'(q_tr[2]), 'hFF);
                chk("dn2_wrap_at_ff", int'(w_tr[2]), 1);
            end
        end

        do_cmd(OP_LOAD, 8'h5A, 8'd0, 0);
        check_cmd("rnd_seed", 8'h5A, 0, 2);
        mq = 8'h5A;
        for (int i = 0; i < 30; i++) begin
            rop   = 2'($urandom_range(0, 3));
            rdata = 8'($urandom);
            rlen  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 20));
            rab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(rlen) + 2)) : 0;
            r     = model(rop, rlen, rab, rdata, mq);
            do_cmd(rop, rdata, rlen, rab);
            check_cmd($sformatf("rnd%0d", i), r.q, r.wraps, r.busy);
            mq = r.q;
        end

        do_cmd(OP_CLEAR, 8'h00, 8'd0, 0);
        check_cmd("pre_rst_clear", 8'h00, 0, 2);
        @(negedge CLK);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = OP_UP;
        cif.cmd_len   = 8'd200;
        @(posedge CLK);
        #1;
        cif.cmd_valid = 1'b0;
        guard  = 0;
        dcount = 0;
        while (q != 8'h40 && guard < 300) begin
            if (done) dcount++;
            @(posedge CLK);
            #1;
            guard++;
        end
        chk("rst_reach_40", int'(q), 'h40);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_async_q", int'(q), 0);
        chk("rst_async_ready", int'(cif.cmd_ready), 1);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_no_done", dcount + int'(done), 0);
        @(negedge CLK);
        RST = 1'b0;
        do_cmd(OP_LOAD, 8'h11, 8'd0, 0);
        check_cmd("post_rst_load", 8'h11, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
